// File: rtl/ex3_pkg.sv
// Shared Excess-3 constants, FSM encodings and legal-code check.
// Used by the accumulator and its digit adder.
package ex3_pkg;

    localparam logic [3:0] EX3_ZERO = 4'b0011;
    localparam logic [3:0] EX3_NINE = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic ex3_legal(input logic [3:0] c);
        return (c >= 4'd3) && (c <= 4'd12);
    endfunction

endpackage

// File: rtl/ex3_digit_adder.sv
// One Excess-3 digit adder: sums two codes plus carry,
// then corrects by +3 (carry) or -3 (no carry).
module ex3_digit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (sum[4]) begin
            s    = sum[3:0] + 4'd3;
            cout = 1'b1;
        end else begin
            s    = sum[3:0] - 4'd3;
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/ex3_accumulator.sv
// Serial Excess-3 accumulator, one digit per cycle.
// Define EX3_ACC_SAT_EN to saturate at all nines on overflow.
module ex3_accumulator
    import ex3_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [3:0]           ex3_in,
    output logic                 in_ready,
    output logic [4*NDIGITS-1:0] acc_out,
    output logic                 out_valid,
    output logic                 overflow,
    output logic                 err
);

    localparam int         W    = 4 * NDIGITS;
    localparam logic [2:0] LAST = 3'(NDIGITS - 1);
`ifdef EX3_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    state_t       state;
    logic [2:0]   idx;
    logic         carry;
    logic [3:0]   addend;
    logic [W-1:0] acc;
    logic [3:0]   cur_a;
    logic [3:0]   cur_b;
    logic [3:0]   sum_d;
    logic         cout;
    logic         accept;
    logic         illegal;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready && ex3_legal(ex3_in);
    assign illegal  = in_valid && in_ready && !ex3_legal(ex3_in);
    assign acc_out  = acc;

    always_comb begin
        cur_a = EX3_ZERO;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx == 3'(i)) cur_a = acc[i*4 +: 4];
        end
    end

    // Only digit 0 sees the new code; higher digits just absorb carry.
    assign cur_b = (idx == 3'd0) ? addend : EX3_ZERO;

    ex3_digit_adder u_digit (
        .a    (cur_a),
        .b    (cur_b),
        .cin  (carry),
        .s    (sum_d),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= 3'd0;
            carry     <= 1'b0;
            addend    <= EX3_ZERO;
            acc       <= {NDIGITS{EX3_ZERO}};
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            if (clear) begin
                state    <= ST_IDLE;
                idx      <= 3'd0;
                carry    <= 1'b0;
                acc      <= {NDIGITS{EX3_ZERO}};
                overflow <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            state  <= ST_ADD;
                            idx    <= 3'd0;
                            carry  <= 1'b0;
                            addend <= ex3_in;
                        end else if (illegal) begin
                            err <= 1'b1;
                        end
                    end
                    ST_ADD: begin
                        for (int i = 0; i < NDIGITS; i++) begin
                            if (idx == 3'(i)) acc[i*4 +: 4] <= sum_d;
                        end
                        carry <= cout;
                        idx   <= idx + 3'd1;
                        if (idx == LAST) begin
                            state <= ST_DONE;
                            if (cout) begin
                                overflow <= 1'b1;
                                if (SAT) acc <= {NDIGITS{EX3_NINE}};
                            end
                        end
                    end
                    ST_DONE: begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex3_accumulator.sv
// Directed bench for ex3_accumulator: 4-digit and 1-digit instances.
// Expected saturation values follow EX3_ACC_SAT_EN.
module tb_ex3_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [3:0]  ex3_in;
    logic        in_ready;
    logic [15:0] acc_out;
    logic        out_valid;
    logic        overflow;
    logic        err;

    logic        v1;
    logic [3:0]  d1;
    logic        r1;
    logic [3:0]  acc1;
    logic        ov1;
    logic        ovf1;
    logic        e1;

    int total = 0;
    int bad   = 0;
    int cyc;
    logic seen_ready;
    logic seen_ov;

`ifdef EX3_ACC_SAT_EN
    localparam logic [3:0] OVF_ACC   = 4'b1100;
    localparam logic [3:0] AFTER_ACC = 4'b1100;
`else
    localparam logic [3:0] OVF_ACC   = 4'b0011;
    localparam logic [3:0] AFTER_ACC = 4'b0011;
`endif

    always #5 clk = ~clk;

    ex3_accumulator #(.NDIGITS(4)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .ex3_in(ex3_in),
        .in_ready(in_ready), .acc_out(acc_out),
        .out_valid(out_valid), .overflow(overflow), .err(err)
    );

    ex3_accumulator #(.NDIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(v1), .ex3_in(d1),
        .in_ready(r1), .acc_out(acc1),
        .out_valid(ov1), .overflow(ovf1), .err(e1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] d);
        in_valid = 1'b1;
        ex3_in   = d;
        step();
        in_valid = 1'b0;
        ex3_in   = 4'b0000;
    endtask

    task automatic wait_done(input string tag);
        cyc        = 0;
        seen_ready = 1'b0;
        repeat (20) begin
            step();
            cyc++;
            if (out_valid) break;
            if (in_ready) seen_ready = 1'b1;
        end
        chk({tag, "_lat"}, cyc, 5);
        chk({tag, "_busy"}, {31'b0, seen_ready}, 0);
    endtask

    task automatic send1(input logic [3:0] d);
        v1 = 1'b1;
        d1 = d;
        step();
        v1 = 1'b0;
        d1 = 4'b0000;
        repeat (3) step();
    endtask

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        ex3_in   = 4'b0000;
        v1       = 1'b0;
        d1       = 4'b0000;
        repeat (2) step();
        chk("rst_acc", acc_out, 16'h3333);
        chk("rst_rdy", in_ready, 1);
        chk("rst_ovf", overflow, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        step();
        chk("rel_acc", acc_out, 16'h3333);
        chk("rel_rdy", in_ready, 1);

        send(4'b0111);
        chk("add4_rdy", in_ready, 0);
        wait_done("add4");
        chk("add4_acc", acc_out, 16'h3337);
        step();
        chk("ov_pulse", out_valid, 0);

        send(4'b1000);
        wait_done("add5");
        chk("add5_acc", acc_out, 16'h333C);

        send(4'b0100);
        wait_done("carry");
        chk("carry_acc", acc_out, 16'h3343);
        chk("carry_ovf", overflow, 0);

        send(4'b1110);
        chk("ill_err", err, 1);
        chk("ill_rdy", in_ready, 1);
        chk("ill_acc", acc_out, 16'h3343);
        step();
        chk("ill_err_end", err, 0);

        send(4'b0111);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_acc", acc_out, 16'h3333);
        chk("clr_rdy", in_ready, 1);
        seen_ov = out_valid;
        repeat (6) begin
            step();
            if (out_valid) seen_ov = 1'b1;
        end
        chk("clr_noov", seen_ov, 0);

        send(4'b1000);
        step();
        rst = 1'b1;
        #1;
        chk("mrst_acc", acc_out, 16'h3333);
        chk("mrst_rdy", in_ready, 1);
        seen_ov = out_valid;
        step();
        rst = 1'b0;
        repeat (6) begin
            step();
            if (out_valid) seen_ov = 1'b1;
        end
        chk("mrst_noov", seen_ov, 0);
        chk("mrst_acc2", acc_out, 16'h3333);

        send1(4'b1000);
        chk("n1_five", acc1, 4'b1000);
        send1(4'b0111);
        chk("n1_nine", acc1, 4'b1100);
        chk("n1_noovf", ovf1, 0);
        send1(4'b0100);
        chk("n1_ovf_acc", acc1, OVF_ACC);
        chk("n1_ovf", ovf1, 1);
        send1(4'b0011);
        chk("n1_stick_acc", acc1, AFTER_ACC);
        chk("n1_sticky", ovf1, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("n1_clr_acc", acc1, 4'b0011);
        chk("n1_clr_ovf", ovf1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex3_accumulator.md
EX3_ACCUMULATOR -- requirements
Module: ex3_accumulator

Interface
REQ-001 The block SHALL have parameter NDIGITS, default 4, giving the number of decimal digits held in the accumulator (legal range 1..8).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 clear  input  1  synchronous clear of the accumulator and flags.
REQ-005 in_valid  input  1  ex3_in carries a digit to add.
REQ-006 ex3_in  input  4  Excess-3 digit from the upstream BCD-to-Excess-3 stage, bit 3 = s3.
REQ-007 in_ready  output  1  the block accepts a digit this cycle.
REQ-008 acc_out  output  4*NDIGITS  accumulated sum as Excess-3 digits, digit 0 in bits [3:0].
REQ-009 out_valid  output  1  one-cycle pulse when an addition completes.
REQ-010 overflow  output  1  sticky flag: the sum exceeded 10^NDIGITS-1.
REQ-011 err  output  1  one-cycle pulse when an illegal code is offered.

Function
REQ-012 A digit SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-013 The state machine SHALL have the states IDLE, ADD and DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 IDLE->ADD SHALL occur on the acceptance of a legal code (0011..1100); the digit index SHALL be set to 0 and the carry to 0.
REQ-015 An illegal code (0000..0010, 1101..1111) offered with in_valid in IDLE SHALL pulse err for 1 cycle, SHALL leave the state in IDLE and SHALL leave acc_out unchanged.
REQ-016 ADD SHALL update exactly one digit per cycle, from digit 0 to NDIGITS-1: addend = ex3_in for digit 0 and 0011 for the other digits, plus the carry.
REQ-017 Digit rule: take the 5-bit sum of the two 4-bit codes plus the carry-in; if bit 4 = 1, digit = low 4 bits + 3 and carry-out = 1; otherwise digit = low 4 bits - 3 and carry-out = 0.
REQ-018 After digit NDIGITS-1 the state SHALL move to DONE; DONE SHALL pulse out_valid and return to IDLE; acceptance to out_valid = NDIGITS+1 cycles.
REQ-019 A carry-out from digit NDIGITS-1 SHALL set overflow; overflow SHALL stay set until rst or clear.
REQ-020 clear SHALL take priority over every other event: it SHALL set every digit to 0011, set overflow to 0, go to IDLE, abort any addition in progress, and not accept a digit in the same cycle.
REQ-021 acc_out SHALL always show valid Excess-3 codes; during ADD the digits not yet updated SHALL hold their old values.

Reset
REQ-022 While rst is asserted: state = IDLE, every acc_out digit = 0011, overflow = 0, out_valid = 0, err = 0, in_ready = 1.
REQ-023 rst asserted in the middle of an addition SHALL discard the addition, with no out_valid pulse.

Configuration
REQ-024 With EX3_ACC_SAT_EN defined, an overflowing addition SHALL leave every digit at 1100 (all nines) in DONE and still set overflow.
REQ-025 Without EX3_ACC_SAT_EN, the sum SHALL wrap modulo 10^NDIGITS.

Structure
REQ-026 The shared package ex3_pkg SHALL hold EX3_ZERO = 4'b0011, EX3_NINE = 4'b1100, the encodings for the IDLE/ADD/DONE states and the legal-code check function.
REQ-027 The one-digit adder SHALL be the combinational sub-module ex3_digit_adder (a, b, cin -> s, cout).

Verification
REQ-028 Reset: assert then release rst -> acc_out = 16'h3333, in_ready = 1, overflow = 0.
REQ-029 Accept 0111 (4), then 1000 (5) -> acc_out = 16'h333C, out_valid pulses 5 cycles after each acceptance, in_ready is 0 between acceptance and DONE.
REQ-030 Carry: from 16'h333C, accept 0100 (1) -> acc_out = 16'h3343.
REQ-031 Overflow with NDIGITS = 1: from acc 1100, accept 0100 -> acc_out = 0011 and overflow = 1; with EX3_ACC_SAT_EN defined -> acc_out = 1100 and overflow = 1.
REQ-032 Offer illegal code 1110 -> err pulses for 1 cycle, acc_out unchanged, in_ready stays 1.
REQ-033 Assert clear in the second ADD cycle -> next cycle acc_out = 16'h3333, state = IDLE, no out_valid pulse.
